// File: rtl/fir_out_collector.sv
// Output stage behind the FIR core: buffers the FIR AXI-Stream output in a small
// FIFO, re-presents it downstream, and checks frame length against tlast.
module fir_out_collector #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pPTR_WIDTH  = 3
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic [31:0]            cfg_length,
    input  logic                   cfg_start,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    output logic                   busy,
    output logic                   done,
    output logic                   err_early_last,
    output logic                   err_missing_last,
    output logic [31:0]            sample_cnt,
    output logic [31:0]            checksum
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [31:0]             len_q;
    logic [31:0]             sample_cnt_q;
    logic [31:0]             checksum_q;
    logic                    early_q;
    logic                    missing_q;
    logic                    done_q;

    logic [pDATA_WIDTH:0]    mem_q [pDEPTH];
    logic [pPTR_WIDTH-1:0]   wr_ptr_q;
    logic [pPTR_WIDTH-1:0]   rd_ptr_q;
    logic [pPTR_WIDTH:0]     count_q;
    logic [pPTR_WIDTH:0]     count_d;

    logic                    full;
    logic                    empty;
    logic                    accept;
    logic                    pop;
    logic                    frame_end;
    logic [31:0]             cnt_inc;
    logic [pDATA_WIDTH:0]    head;

    assign full      = (count_q == (pPTR_WIDTH+1)'(pDEPTH));
    assign empty     = (count_q == '0);
    assign ss_tready = (state_q == RUN) && !full;
    assign accept    = ss_tvalid && ss_tready;
    assign pop       = !empty && sm_tready;
    assign cnt_inc   = sample_cnt_q + 32'd1;
    assign frame_end = accept && (ss_tlast || (cnt_inc == len_q));

    // Head entry is gated so the data/last outputs read zero whenever nothing is valid.
    assign head      = mem_q[rd_ptr_q];
    assign sm_tvalid = !empty;
    assign sm_tdata  = empty ? '0 : head[pDATA_WIDTH-1:0];
    assign sm_tlast  = empty ? 1'b0 : head[pDATA_WIDTH];

    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign err_early_last   = early_q;
    assign err_missing_last = missing_q;
    assign sample_cnt       = sample_cnt_q;
    assign checksum         = checksum_q;

    always_ff @(posedge axis_clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {frame_end, ss_tdata};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + (pPTR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (pPTR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + pPTR_WIDTH'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + pPTR_WIDTH'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            sample_cnt_q <= '0;
            checksum_q   <= '0;
            early_q      <= 1'b0;
            missing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start && (cfg_length != 32'd0)) begin
                        len_q        <= cfg_length;
                        sample_cnt_q <= '0;
                        checksum_q   <= '0;
                        early_q      <= 1'b0;
                        missing_q    <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sample_cnt_q <= cnt_inc;
                        checksum_q   <= checksum_q + 32'($signed(ss_tdata));
                        if (frame_end) begin
                            if (ss_tlast && (cnt_inc != len_q))  early_q   <= 1'b1;
                            if (!ss_tlast && (cnt_inc == len_q)) missing_q <= 1'b1;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Nothing is pushed here, so popping the last entry empties the FIFO.
                    if (pop && (count_q == (pPTR_WIDTH+1)'(1))) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
